// File: rtl/bus_mux_pkg.sv
// Shared definitions for the datapath operand selector: source codes and
// skid-buffer occupancy encoding.
package bus_mux_pkg;

    typedef enum logic [1:0] {
        SRC_REG  = 2'b00,
        SRC_IR   = 2'b01,
        SRC_IMM  = 2'b10,
        SRC_NONE = 2'b11
    } src_e;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } occ_e;

endpackage

// File: rtl/bus_skid_buf.sv
// Two-entry valid/ready skid buffer. in_ready and out_valid are registered,
// so the consumer's out_ready never reaches in_ready combinationally.
module bus_skid_buf
    import bus_mux_pkg::*;
#(
    parameter int PW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    occ_e          state_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic          out_valid_q;
    logic          in_ready_q;
    logic          accept;
    logic          pop;

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_q && out_ready;

    // head_q is always the word on the output; tail_q only holds the second
    // entry while the consumer is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q      <= in_data;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_q <= in_data;
                    end else if (accept) begin
                        tail_q     <= in_data;
                        state_q    <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q     <= tail_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/bus_operand_mux.sv
// Registered operand selector: immediate > IR > register priority, sticky
// out-of-range flag. Define BUS_OPERAND_MUX_SEXT_EN to sign-extend the immediate.
module bus_operand_mux
    import bus_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int SEL_W = $clog2(NREG),
    parameter int IMM_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH*NREG-1:0] regs_flat,
    input  logic [WIDTH-1:0]      ir_in,
    input  logic [IMM_W-1:0]      imm_in,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  r_sel,
    input  logic                  imm_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [1:0]            out_src,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int PW = WIDTH + 2;

    logic [WIDTH-1:0] regWord;
    logic [WIDTH-1:0] immExt;
    logic [WIDTH-1:0] selData;
    src_e             selSrc;
    logic             badReq;
    logic             accept;
    logic [PW-1:0]    bufIn;
    logic [PW-1:0]    bufOut;
    logic             err_q;
    logic             err_d;

    // Explicit compare loop keeps an out-of-range sel from indexing past regs_flat.
    always_comb begin
        regWord = '0;
        for (int k = 0; k < NREG; k++) begin
            if (sel == SEL_W'(k)) begin
                regWord = regs_flat[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef BUS_OPERAND_MUX_SEXT_EN
    assign immExt = WIDTH'($signed(imm_in));
`else
    assign immExt = WIDTH'(imm_in);
`endif

    assign badReq = !imm_sel && !r_sel && (int'(sel) >= NREG);

    always_comb begin
        selData = regWord;
        selSrc  = SRC_REG;
        if (imm_sel) begin
            selData = immExt;
            selSrc  = SRC_IMM;
        end else if (r_sel) begin
            selData = ir_in;
            selSrc  = SRC_IR;
        end else if (badReq) begin
            selData = '0;
            selSrc  = SRC_NONE;
        end
    end

    assign bufIn  = {selSrc, selData};
    assign accept = in_valid && in_ready;

    // A new bad request wins over a simultaneous clear so no error is lost.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (accept && badReq) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    bus_skid_buf #(
        .PW(PW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (bufIn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (bufOut),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_data = bufOut[WIDTH-1:0];
    assign out_src  = bufOut[PW-1 -: 2];
    assign err      = err_q;

endmodule

// File: tb/tb_bus_operand_mux.sv
// Scoreboard bench for bus_operand_mux (NREG=6 so out-of-range selects exist).
module tb_bus_operand_mux;
    import bus_mux_pkg::*;

    localparam int WIDTH = 16;
    localparam int NREG  = 6;
    localparam int SEL_W = 3;
    localparam int IMM_W = 9;

    logic                  clk;
    logic                  rst_n;
    logic [WIDTH*NREG-1:0] regs_flat;
    logic [WIDTH-1:0]      ir_in;
    logic [IMM_W-1:0]      imm_in;
    logic [SEL_W-1:0]      sel;
    logic                  r_sel;
    logic                  imm_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_src;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err;
    logic                  err_clr;

    logic [WIDTH-1:0] regVals [NREG];
    logic [17:0]      expQ [$];
    int               checks = 0;
    int               errors = 0;
    bit               randRun;

    bus_operand_mux #(
        .WIDTH(WIDTH),
        .NREG (NREG),
        .SEL_W(SEL_W),
        .IMM_W(IMM_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .regs_flat(regs_flat),
        .ir_in    (ir_in),
        .imm_in   (imm_in),
        .sel      (sel),
        .r_sel    (r_sel),
        .imm_sel  (imm_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] immExpected(input logic [8:0] v);
`ifdef BUS_OPERAND_MUX_SEXT_EN
        return {{7{v[8]}}, v};
`else
        return {7'b0, v};
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] s, input logic r, input logic im,
                                 input logic [15:0] irv, input logic [8:0] immv,
                                 input logic [15:0] expD, input logic [1:0] expS);
        bit accepted = 0;
        sel      = s;
        r_sel    = r;
        imm_sel  = im;
        ir_in    = irv;
        imm_in   = immv;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin
                expQ.push_back({expS, expD});
                accepted = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 100; c++) begin
            if (expQ.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_empty", 18'(expQ.size()), 18'd0);
    endtask

    // Monitor: every presented word must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_unexpected: got %h expected no output", {out_src, out_data});
                end else begin
                    checkOutput("scoreboard", {out_src, out_data}, expQ[0]);
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        sel       = '0;
        r_sel     = 1'b0;
        imm_sel   = 1'b0;
        ir_in     = '0;
        imm_in    = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        regVals   = '{16'hA000, 16'h0B01, 16'hC0C2, 16'h1234, 16'h5E54, 16'hF0F5};
        for (int k = 0; k < NREG; k++) regs_flat[k*WIDTH +: WIDTH] = regVals[k];

        #2 rst_n = 1'b0;
        #6;
        checkOutput("reset_out_valid", 18'(out_valid), 18'd0);
        checkOutput("reset_out_word", {out_src, out_data}, 18'h0);
        checkOutput("reset_err", 18'(err), 18'd0);
        #14 rst_n = 1'b1;
        checkOutput("reset_in_ready", 18'(in_ready), 18'd1);
        @(posedge clk);
        #1;

        $display("[TB] basic selection and priority");
        out_ready = 1'b1;
        applyStimulus(3'd3, 1'b0, 1'b0, 16'hBEEF, 9'h000, 16'h1234, SRC_REG);
        checkOutput("latency_valid", 18'(out_valid), 18'd1);
        checkOutput("latency_word", {out_src, out_data}, {SRC_REG, 16'h1234});
`ifdef BUS_OPERAND_MUX_SEXT_EN
        applyStimulus(3'd0, 1'b1, 1'b1, 16'hBEEF, 9'h1FF, 16'hFFFF, SRC_IMM);
`else
        applyStimulus(3'd0, 1'b1, 1'b1, 16'hBEEF, 9'h1FF, 16'h01FF, SRC_IMM);
`endif
        applyStimulus(3'd5, 1'b1, 1'b0, 16'hBEEF, 9'h0AA, 16'hBEEF, SRC_IR);
        applyStimulus(3'd1, 1'b0, 1'b0, 16'h0000, 9'h000, 16'h0B01, SRC_REG);
        applyStimulus(3'd2, 1'b0, 1'b1, 16'h0000, 9'h0A5, 16'h00A5, SRC_IMM);
        waitDrain();

        $display("[TB] out-of-range select and err flag");
        applyStimulus(3'd7, 1'b0, 1'b0, 16'h0000, 9'h000, 16'h0000, SRC_NONE);
        checkOutput("err_set", 18'(err), 18'd1);
        err_clr = 1'b1;
        applyStimulus(3'd6, 1'b0, 1'b0, 16'h0000, 9'h000, 16'h0000, SRC_NONE);
        err_clr = 1'b0;
        checkOutput("err_set_beats_clr", 18'(err), 18'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checkOutput("err_cleared", 18'(err), 18'd0);
        applyStimulus(3'd7, 1'b1, 1'b0, 16'h7777, 9'h000, 16'h7777, SRC_IR);
        checkOutput("err_ir_not_oob", 18'(err), 18'd0);
        waitDrain();

        $display("[TB] back-pressure fills both entries");
        out_ready = 1'b0;
        applyStimulus(3'd0, 1'b0, 1'b0, 16'h0000, 9'h000, 16'hA000, SRC_REG);
        applyStimulus(3'd2, 1'b0, 1'b0, 16'h0000, 9'h000, 16'hC0C2, SRC_REG);
        fork
            applyStimulus(3'd4, 1'b0, 1'b0, 16'h0000, 9'h000, 16'h5E54, SRC_REG);
            begin
                checkOutput("full_in_ready", 18'(in_ready), 18'd0);
                @(posedge clk);
                #1;
                checkOutput("full_in_ready_hold", 18'(in_ready), 18'd0);
                out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] reset while full");
        out_ready = 1'b0;
        applyStimulus(3'd1, 1'b0, 1'b0, 16'h0000, 9'h000, 16'h0B01, SRC_REG);
        applyStimulus(3'd3, 1'b0, 1'b0, 16'h0000, 9'h000, 16'h1234, SRC_REG);
        checkOutput("pre_reset_in_ready", 18'(in_ready), 18'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 18'(out_valid), 18'd0);
        expQ.delete();
        #2 rst_n = 1'b1;
        checkOutput("post_reset_in_ready", 18'(in_ready), 18'd1);
        checkOutput("post_reset_valid", 18'(out_valid), 18'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("no_stale_word", 18'(out_valid), 18'd0);

        $display("[TB] random out_ready stream");
        randRun = 1;
        fork
            begin
                while (randRun) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 500; i++) begin
                    int          kind;
                    logic [2:0]  s;
                    logic [15:0] irv;
                    logic [8:0]  immv;
                    kind = int'($urandom_range(0, 3));
                    s    = 3'($urandom_range(0, NREG - 1));
                    irv  = 16'($urandom);
                    immv = 9'($urandom);
                    if (kind == 2)
                        applyStimulus(s, 1'b1, 1'b0, irv, immv, irv, SRC_IR);
                    else if (kind == 3)
                        applyStimulus(s, 1'($urandom_range(0, 1)), 1'b1, irv, immv, immExpected(immv), SRC_IMM);
                    else
                        applyStimulus(s, 1'b0, 1'b0, irv, immv, regVals[s], SRC_REG);
                end
                randRun = 0;
            end
        join
        out_ready = 1'b1;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
